// File: rtl/nes_input_events.sv
// nes_input_events: frame-rate sampling, two-sample debounce, D-pad auto-repeat
// and clear-on-read press/release event registers for the NES controller.
//
// Ports:
//   clock           system clock, all logic on posedge
//   reset           asynchronous active-low reset
//   controller_data live buttons {A,B,Select,Start,Up,Down,Left,Right}, 1 = pressed
//   rd_en, rd_sel   one-cycle read strobe and register select
//                   (0 state, 1 press events, 2 release events, 3 status)
//   rd_data         registered read data, holds until the next rd_en
//   irq_mask        per-button interrupt enable
//   irq             level interrupt, |(press_pend & irq_mask)
module nes_input_events #(
  parameter int unsigned SAMPLE_PERIOD = 833334,
  parameter int unsigned REPEAT_DELAY  = 30,
  parameter int unsigned REPEAT_RATE   = 6,
  parameter logic [7:0]  REPEAT_MASK   = 8'h0F
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] controller_data,
  input  logic       rd_en,
  input  logic [1:0] rd_sel,
  output logic [7:0] rd_data,
  input  logic [7:0] irq_mask,
  output logic       irq
);

  localparam int unsigned CNT_W = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam int unsigned HOLD_W = 8;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DELAY  = 2'd1;
  localparam logic [1:0] ST_REPEAT = 2'd2;

  logic [CNT_W-1:0]  tick_cnt;
  logic              tick;
  logic [7:0]        last;
  logic [7:0]        db;
  logic [7:0]        new_db;
  logic [7:0]        rise;
  logic [7:0]        fall;
  logic [7:0]        m;
  logic [7:0]        mo;
  logic [7:0]        press_pend;
  logic [7:0]        release_pend;
  logic              overrun;
  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic [HOLD_W-1:0] hold_cnt;
  logic [HOLD_W-1:0] hold_nxt;
  logic [7:0]        rep_fire;
  logic [7:0]        press_set;
  logic              rd_press;
  logic              rd_release;
  logic              rd_status;
  logic [7:0]        rd_mux;

  assign tick = (tick_cnt == CNT_W'(SAMPLE_PERIOD - 1));

  // Debounce: a sample only reaches db once it matched the previous sample.
  // Off-tick new_db equals db, so edges and the FSM stay quiet between ticks.
  always_comb begin
    new_db = db;
    if (tick && (controller_data == last)) new_db = controller_data;
  end

  assign rise      = new_db & ~db;
  assign fall      = ~new_db & db;
  assign m         = new_db & REPEAT_MASK;
  assign mo        = db & REPEAT_MASK;
  assign press_set = rise | rep_fire;

  // Auto-repeat next-state: hold_cnt is compared before incrementing so the
  // first fire lands REPEAT_DELAY ticks after the last change of m.
  always_comb begin
    state_nxt = state;
    hold_nxt  = hold_cnt;
    rep_fire  = 8'h00;
    if (tick) begin
      case (state)
        ST_IDLE: begin
          if (m != 8'h00) begin
            state_nxt = ST_DELAY;
            hold_nxt  = '0;
          end
        end
        ST_DELAY: begin
          if (m == 8'h00) begin
            state_nxt = ST_IDLE;
          end else if (m != mo) begin
            hold_nxt = '0;
          end else if (hold_cnt == HOLD_W'(REPEAT_DELAY - 1)) begin
            rep_fire  = m;
            state_nxt = ST_REPEAT;
            hold_nxt  = '0;
          end else begin
            hold_nxt = hold_cnt + HOLD_W'(1);
          end
        end
        ST_REPEAT: begin
          if (m == 8'h00) begin
            state_nxt = ST_IDLE;
          end else if (m != mo) begin
            state_nxt = ST_DELAY;
            hold_nxt  = '0;
          end else if (hold_cnt == HOLD_W'(REPEAT_RATE - 1)) begin
            rep_fire = m;
            hold_nxt = '0;
          end else begin
            hold_nxt = hold_cnt + HOLD_W'(1);
          end
        end
        default: begin
          state_nxt = ST_IDLE;
          hold_nxt  = '0;
        end
      endcase
    end
  end

  // Repeat FSM state register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      hold_cnt <= '0;
    end else begin
      state    <= state_nxt;
      hold_cnt <= hold_nxt;
    end
  end

  assign rd_press   = rd_en && (rd_sel == 2'd1);
  assign rd_release = rd_en && (rd_sel == 2'd2);
  assign rd_status  = rd_en && (rd_sel == 2'd3);

  assign irq = |(press_pend & irq_mask);

  // Read mux sees pre-edge register values
  always_comb begin
    rd_mux = 8'h00;
    case (rd_sel)
      2'd0:    rd_mux = db;
      2'd1:    rd_mux = press_pend;
      2'd2:    rd_mux = release_pend;
      default: rd_mux = {irq, overrun, 6'b000000};
    endcase
  end

  // Sampling, debounce and event registers; a clear on the same edge as a new
  // event leaves exactly the new bits so nothing is lost.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tick_cnt     <= '0;
      last         <= 8'h00;
      db           <= 8'h00;
      press_pend   <= 8'h00;
      release_pend <= 8'h00;
      overrun      <= 1'b0;
      rd_data      <= 8'h00;
    end else begin
      if (tick) begin
        tick_cnt <= '0;
        last     <= controller_data;
      end else begin
        tick_cnt <= tick_cnt + CNT_W'(1);
      end
      db           <= new_db;
      press_pend   <= (rd_press ? 8'h00 : press_pend) | press_set;
      release_pend <= (rd_release ? 8'h00 : release_pend) | fall;
      overrun      <= (rd_status ? 1'b0 : overrun) | (|(press_set & press_pend));
      if (rd_en) rd_data <= rd_mux;
    end
  end

endmodule

// File: tb/tb_nes_input_events.sv
// Self-checking bench for nes_input_events with a short sample period.
module tb_nes_input_events;

  localparam int unsigned SP = 10;

  logic       clock;
  logic       reset;
  logic [7:0] controller_data;
  logic       rd_en;
  logic [1:0] rd_sel;
  logic [7:0] rd_data;
  logic [7:0] irq_mask;
  logic       irq;

  int checks;
  int failures;
  int tb_cnt;
  int ticks;
  logic [7:0] exp_q[$];

  nes_input_events #(
    .SAMPLE_PERIOD(SP),
    .REPEAT_DELAY (3),
    .REPEAT_RATE  (2),
    .REPEAT_MASK  (8'h0F)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .controller_data(controller_data),
    .rd_en          (rd_en),
    .rd_sel         (rd_sel),
    .rd_data        (rd_data),
    .irq_mask       (irq_mask),
    .irq            (irq)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Bench-side sample tick model: ticks counts tick edges since reset release
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      tb_cnt <= 0;
      ticks  <= 0;
    end else if (tb_cnt == SP - 1) begin
      tb_cnt <= 0;
      ticks  <= ticks + 1;
    end else begin
      tb_cnt <= tb_cnt + 1;
    end
  end

  task automatic apply_reset(input logic [7:0] data);
    @(negedge clock);
    reset = 1'b0;
    controller_data = data;
    rd_en = 1'b0;
    rd_sel = 2'd0;
    exp_q.delete();
    repeat (3) @(negedge clock);
    reset = 1'b1;
  endtask

  // Returns at the negedge following the n-th further tick edge
  task automatic wait_ticks(input int n, input string name);
    int target;
    int guard;
    target = ticks + n;
    guard = 0;
    while (ticks < target && guard < (SP + 2) * n + 4) begin
      @(negedge clock);
      guard++;
    end
    if (ticks < target) begin
      checks++;
      failures++;
      $display("FAIL %s: tick wait expired, ticks=%0d required=%0d", name, ticks, target);
    end
  endtask

  // Returns at the negedge just before a tick edge
  task automatic wait_pre_tick();
    int guard;
    guard = 0;
    while (tb_cnt != SP - 1 && guard < SP + 2) begin
      @(negedge clock);
      guard++;
    end
    if (tb_cnt != SP - 1) begin
      checks++;
      failures++;
      $display("FAIL pre_tick: wait expired");
    end
  endtask

  // Read: expectation queued at the strobe, popped and compared after the edge
  task automatic do_read(input logic [1:0] sel, input logic [7:0] expv, input string name);
    logic [7:0] e;
    rd_en = 1'b1;
    rd_sel = sel;
    exp_q.push_back(expv);
    @(negedge clock);
    rd_en = 1'b0;
    e = exp_q.pop_front();
    checks++;
    if (rd_data !== e) begin
      failures++;
      $display("FAIL %s: rd_data=%h required=%h", name, rd_data, e);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    controller_data = 8'h00;
    rd_en = 1'b0;
    rd_sel = 2'd0;
    irq_mask = 8'hFF;
    repeat (2) @(negedge clock);
    checks++;
    if (rd_data !== 8'h00 || irq !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: rd_data=%h irq=%b required=00/0", rd_data, irq);
    end
    apply_reset(8'h00);
    wait_ticks(3, "reset_idle");
    do_read(2'd0, 8'h00, "reset_db");
    do_read(2'd3, 8'h00, "reset_status");
  endtask

  task automatic test_hold_from_reset();
    irq_mask = 8'h00;
    apply_reset(8'h80);
    wait_ticks(1, "hold_t1");
    do_read(2'd0, 8'h00, "hold_db_tick1");
    wait_ticks(1, "hold_t2");
    do_read(2'd0, 8'h80, "hold_db_tick2");
    do_read(2'd1, 8'h80, "hold_press");
    do_read(2'd1, 8'h00, "hold_press_cleared");
    do_read(2'd2, 8'h00, "hold_release");
  endtask

  task automatic test_glitch();
    apply_reset(8'h00);
    wait_ticks(1, "glitch_t1");
    controller_data = 8'h40;
    wait_ticks(1, "glitch_t2");
    controller_data = 8'h00;
    wait_ticks(3, "glitch_t5");
    do_read(2'd0, 8'h00, "glitch_db");
    do_read(2'd1, 8'h00, "glitch_press");
    do_read(2'd2, 8'h00, "glitch_release");
  endtask

  task automatic test_repeat();
    apply_reset(8'h08);
    wait_ticks(2, "rep_t2");
    do_read(2'd1, 8'h08, "rep_edge_t2");
    wait_ticks(2, "rep_t4");
    do_read(2'd1, 8'h00, "rep_none_t4");
    wait_ticks(1, "rep_t5");
    do_read(2'd1, 8'h08, "rep_fire_t5");
    wait_ticks(1, "rep_t6");
    do_read(2'd1, 8'h00, "rep_none_t6");
    wait_ticks(1, "rep_t7");
    do_read(2'd1, 8'h08, "rep_fire_t7");
    wait_ticks(2, "rep_t9");
    do_read(2'd1, 8'h08, "rep_fire_t9");
    controller_data = 8'h0A;
    wait_ticks(2, "rep_t11");
    do_read(2'd0, 8'h0A, "rep_db_0a");
    do_read(2'd1, 8'h02, "rep_new_edge");
    wait_ticks(2, "rep_t13");
    do_read(2'd1, 8'h00, "rep_restart_quiet");
    wait_ticks(1, "rep_t14");
    do_read(2'd1, 8'h0A, "rep_restart_fire");
  endtask

  task automatic test_irq();
    irq_mask = 8'h10;
    apply_reset(8'h00);
    wait_ticks(1, "irq_t1");
    controller_data = 8'h10;
    wait_ticks(1, "irq_t2");
    wait_pre_tick();
    checks++;
    if (irq !== 1'b0) begin
      failures++;
      $display("FAIL irq_before: irq=%b required=0", irq);
    end
    @(negedge clock);
    checks++;
    if (irq !== 1'b1) begin
      failures++;
      $display("FAIL irq_rise: irq=%b required=1", irq);
    end
    do_read(2'd1, 8'h10, "irq_press");
    checks++;
    if (irq !== 1'b0) begin
      failures++;
      $display("FAIL irq_fall: irq=%b required=0", irq);
    end
    controller_data = 8'h80;
    wait_ticks(2, "irq_a");
    checks++;
    if (irq !== 1'b0) begin
      failures++;
      $display("FAIL irq_masked: irq=%b required=0", irq);
    end
    do_read(2'd1, 8'h80, "irq_a_press");
    do_read(2'd2, 8'h10, "irq_start_release");
  endtask

  task automatic test_back_to_back();
    irq_mask = 8'h08;
    apply_reset(8'h00);
    wait_ticks(1, "b2b_t1");
    controller_data = 8'h20;
    wait_ticks(2, "b2b_t3");
    controller_data = 8'h60;
    wait_ticks(1, "b2b_t4");
    wait_pre_tick();
    do_read(2'd1, 8'h20, "b2b_read_on_tick");
    do_read(2'd1, 8'h40, "b2b_new_bit_kept");
    controller_data = 8'h68;
    wait_ticks(4, "b2b_t9");
    do_read(2'd3, 8'h80, "b2b_status_pending");
    wait_ticks(1, "b2b_t10");
    do_read(2'd3, 8'hC0, "b2b_overrun");
    do_read(2'd3, 8'h80, "b2b_overrun_cleared");
    do_read(2'd1, 8'h08, "b2b_press_up");
    checks++;
    if (irq !== 1'b0) begin
      failures++;
      $display("FAIL b2b_irq_drop: irq=%b required=0", irq);
    end
  endtask

  task automatic test_reset_mid();
    irq_mask = 8'hFF;
    apply_reset(8'h08);
    wait_ticks(3, "mid_t3");
    do_read(2'd0, 8'h08, "mid_db");
    checks++;
    if (irq !== 1'b1) begin
      failures++;
      $display("FAIL mid_irq_pending: irq=%b required=1", irq);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (rd_data !== 8'h00 || irq !== 1'b0) begin
      failures++;
      $display("FAIL mid_async_clear: rd_data=%h irq=%b required=00/0", rd_data, irq);
    end
    repeat (3) @(negedge clock);
    reset = 1'b1;
    wait_ticks(1, "mid_r1");
    do_read(2'd1, 8'h00, "mid_no_early_press");
    wait_ticks(1, "mid_r2");
    do_read(2'd1, 8'h08, "mid_repress");
    wait_ticks(2, "mid_r4");
    do_read(2'd1, 8'h00, "mid_no_early_repeat");
    wait_ticks(1, "mid_r5");
    do_read(2'd1, 8'h08, "mid_repeat_r5");
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_hold_from_reset();
    test_glitch();
    test_repeat();
    test_irq();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/nes_input_events.md
Name: nes_input_events

Overview:
Consumes the 8-bit live button vector produced by the NES controller reader (A,B,Select,Start,Up,Down,Left,Right in bits 7..0, active-high) and turns it into debounced state plus sticky press/release events for the Titan processor. It samples once per frame tick, debounces across two consecutive samples and generates D-pad auto-repeat. It exposes a 4-register read port with clear-on-read event registers and a level interrupt.

Parameters:
SAMPLE_PERIOD, 833334, clocks per sample tick (60 Hz at 50 MHz); counter width $clog2(SAMPLE_PERIOD)
REPEAT_DELAY, 30, ticks a repeat-masked set must be held before first auto-repeat (1..255)
REPEAT_RATE, 6, ticks between subsequent auto-repeats (1..255)
REPEAT_MASK, 8'h0F, buttons eligible for auto-repeat (D-pad)

Ports:
clock  in  1  system clock, all logic on posedge
reset  in  1  asynchronous, active-low reset
controller_data  in  8  live button vector from the controller reader, 1 = pressed
rd_en  in  1  read strobe, one cycle
rd_sel  in  2  0 = debounced state, 1 = press events, 2 = release events, 3 = status
rd_data  out  8  registered read data
irq_mask  in  8  per-button enable for irq
irq  out  1  level interrupt = |(press_pend & irq_mask)

Behaviour:
- Reset (reset low, async): tick_cnt, last, db, press_pend, release_pend, overrun, hold_cnt, rd_data = 0; repeat FSM = IDLE; irq = 0.
- tick_cnt counts 0..SAMPLE_PERIOD-1 and wraps. tick = (tick_cnt == SAMPLE_PERIOD-1). No other logic advances between ticks.
- On the tick edge: last <= controller_data. If controller_data == last, then db <= controller_data; otherwise db holds. A change must be present on two consecutive ticks to reach db.
- Edges on the same tick edge as the db update: rise = new_db & ~db, fall = ~new_db & db.
  - press_pend |= rise | rep_fire.
  - release_pend |= fall.
  - overrun set if (rise | rep_fire) & press_pend is nonzero.
- Repeat FSM, on tick only. m = new_db & REPEAT_MASK, mo = db & REPEAT_MASK.
  - IDLE: if m != 0, go to DELAY with hold_cnt = 0.
  - DELAY: if m == 0, go to IDLE. Else if m != mo, hold_cnt = 0. Else hold_cnt++. When hold_cnt reaches REPEAT_DELAY-1 with m unchanged, set rep_fire = m, go to REPEAT, hold_cnt = 0.
  - REPEAT: if m == 0, go to IDLE. If m != mo, go to DELAY with hold_cnt = 0. Else hold_cnt++. At REPEAT_RATE-1, rep_fire = m and hold_cnt = 0.
  - Result: first repeat fires REPEAT_DELAY ticks after the tick where m last changed, then every REPEAT_RATE ticks.
  - hold_cnt is 8 bits.
- Read port:
  - rd_en in cycle N loads rd_data at edge N+1. rd_data holds until the next rd_en.
  - sel 0 returns db.
  - sel 1 returns press_pend and clears it.
  - sel 2 returns release_pend and clears it.
  - sel 3 returns {irq, overrun, 6'b0} and clears overrun.
- Simultaneous clear-on-read and new event on the same edge: the returned value is the pre-event value. After the edge the register holds exactly the new event bits, so no event is lost.
- irq is combinational from the registers and drops the cycle after a sel-1 read, unless new events arrive.
- A button held through reset deassertion produces a press event two ticks after reset release.
- Reset asserted mid-sequence clears all state immediately. No partial event survives.

Test Plan:
Bench parameters: SAMPLE_PERIOD=10, REPEAT_DELAY=3, REPEAT_RATE=2.
1. Hold controller_data=8'h80 from reset release. Result: db=8'h80 after tick 2. A read with sel 1 returns 8'h80. A second sel-1 read returns 8'h00.
2. Glitch 8'h40 for exactly one tick window, then return to 8'h00. Result: db stays 8'h00, and both press_pend and release_pend stay 8'h00.
3. Hold 8'h08 (Up). Result: press edge at tick 2, then rep_fire at ticks 5, 7 and 9. Reading sel 1 after each fire returns 8'h08. Changing to 8'h0A restarts DELAY: new edge for bit 1, next repeat 3 ticks later.
4. With irq_mask=8'h10, press Start (8'h10). Result: irq rises on the db-update edge. A sel-1 read returns 8'h10 and irq falls the next cycle. Pressing A alone (8'h80) leaves irq=0.
5. Issue the sel-1 read on the exact tick edge where a second press rises. Result: rd_data holds the old value, press_pend holds the new bit afterwards. A repeat onto an unread pending bit sets status bit 6, and a sel-3 read clears it.
6. Assert reset low mid-DELAY with events pending. Result: all outputs are 0 at once, asynchronously. After release, a held button re-reports its press at tick 2.
